prog_load_run_ctrl: RTL and testbench
=====================================

Name: prog_load_run_ctrl

Overview:
Sequencer that owns the single-cycle RISC-V core's instruction memory and reset.
- Streams a program (addi/add/beq/jal words) into instruction memory over a valid/ready port.
- Releases the core, counts execution cycles and detects the halt idiom (jal x0,0).
- Reports done or timeout, so the Fibonacci bench and top level run programs without hierarchical pokes.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 6, instruction memory word-address width (64 words)
CNT_WIDTH, 16, execution cycle counter width
MAX_CYCLES, 1000, run-cycle budget before timeout (must be < 2**CNT_WIDTH)
HALT_INSTR, 32'h0000006F, encoding treated as halt (jal x0,0)

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin load of a new program
abort  in  1  pulse; return to IDLE from any state
prog_len  in  ADDR_WIDTH+1  words to load (1..2**ADDR_WIDTH), sampled on accepted start
in_valid  in  1  program word valid
in_ready  out  1  controller accepts word
in_instr  in  DATA_WIDTH  program word
mem_we  out  1  instruction memory write enable
mem_waddr  out  ADDR_WIDTH  write word address
mem_wdata  out  DATA_WIDTH  write data
core_rst_n  out  1  active-low reset to core (0 = held)
cur_instr  in  DATA_WIDTH  instruction currently decoded by core
busy  out  1  state is LOAD or RUN
done  out  1  program finished (halt or timeout)
timeout  out  1  finished by budget expiry
cycle_count  out  CNT_WIDTH  core cycles executed in last/current run

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, core_rst_n 0, busy 0, done 0, timeout 0, cycle_count 0.
- Reset mid-operation: immediate return to these values. Partially loaded memory content is not erased.
- All outputs are registered except in_ready, which is decoded from state (1 only in LOAD).
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start with prog_len in 1..2**ADDR_WIDTH -> LOAD; latch prog_len; word counter = 0.
  - start with prog_len 0 or out of range -> ignored.
- LOAD:
  - Accept a word when in_valid & in_ready.
  - Cycle after accept: mem_we=1, mem_waddr=word counter, mem_wdata=the accepted word. One write per accept, no gaps required.
  - in_valid low: no write; mem_we=0.
  - Accept of word prog_len-1 -> RUN next cycle. in_ready drops that same cycle, so no extra word is taken.
- RUN:
  - core_rst_n=1 from the first RUN cycle.
  - cycle_count clears on RUN entry, then increments by 1 each RUN cycle. It saturates and never wraps.
  - cur_instr==HALT_INSTR -> DONE; done=1, timeout=0.
  - cycle_count reaching MAX_CYCLES-1 without halt -> DONE; done=1, timeout=1.
  - Halt and budget expiry in the same cycle: halt wins, timeout=0.
- DONE:
  - core_rst_n=0 (core frozen). done, timeout and cycle_count hold.
  - start (valid prog_len) -> LOAD; done and timeout clear on that transition.
- start while in LOAD or RUN: ignored.
- abort: -> IDLE from any state next cycle. core_rst_n=0, in_ready=0, mem_we=0, done=0, timeout=0; cycle_count holds.
- abort and start in the same cycle: abort wins.

Test Plan:
1. Reset, start with prog_len=4, four back-to-back words (addi x1,x0,1 / addi x2,x0,1 / add x3,x1,x2 / 0x0000006F) -> mem_we on cycles 1-4 after accepts, waddr 0..3 with matching data, then RUN. Halt seen on the core's 4th fetch -> done=1, timeout=0, cycle_count=3, core_rst_n=0.
2. prog_len=3 with in_valid toggling 1,0,1,0,1 -> exactly 3 writes (addr 0,1,2). in_ready low after the 3rd accept; a 4th valid word is not accepted.
3. Program never halts (beq x0,x0,0 loop), MAX_CYCLES=1000 -> done=1, timeout=1, cycle_count=999.
4. cur_instr=HALT_INSTR on the same cycle cycle_count hits MAX_CYCLES-1 -> timeout=0, done=1.
5. abort during LOAD after 2 of 5 words, and separately during RUN -> IDLE next cycle, in_ready=0, core_rst_n=0, done=0. A following start with prog_len=0 is ignored (stays IDLE).
6. arst_n pulsed low mid-RUN -> all outputs at reset values asynchronously. Restart with start, prog_len=1 (HALT_INSTR) -> done after cycle_count=0.

Source files
------------

// File: rtl/prog_load_run_ctrl.sv
// Program loader and run sequencer for the single-cycle core.
// Owns imem writes and core reset, detects halt or budget expiry.
module prog_load_run_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h0000006F
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_rst_n,
  input  logic [DATA_WIDTH-1:0] cur_instr,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] wcnt_q;

  logic start_ok;
  logic launch;
  logic accept;
  logic last_word;
  logic halt;
  logic budget_out;
  logic run_entry;
  logic run_stay;

  assign start_ok = start
                  && (prog_len != '0)
                  && (prog_len <= MAX_LEN);

  assign launch = !abort && start_ok
                && ((state == IDLE) || (state == DONE));

  assign in_ready = (state == LOAD);
  assign accept = in_valid && in_ready;
  assign last_word = (wcnt_q == (len_q - LEN_ONE));

  assign halt = (cur_instr == HALT_INSTR);
  assign budget_out = (cycle_count == LAST_CYCLE);

  assign run_entry = (state != RUN) && (state_nxt == RUN);
  assign run_stay = (state == RUN) && (state_nxt == RUN);

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides everything.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start_ok) state_nxt = LOAD;
        LOAD: if (accept && last_word) state_nxt = RUN;
        RUN:  if (halt || budget_out) state_nxt = DONE;
        DONE: if (start_ok) state_nxt = LOAD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Load path: latch length, count words, register imem writes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      len_q     <= '0;
      wcnt_q    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept && !abort;
      if (launch) begin
        len_q  <= prog_len;
        wcnt_q <= '0;
      end
      if (accept && !abort) begin
        mem_waddr <= wcnt_q[ADDR_WIDTH-1:0];
        mem_wdata <= in_instr;
        wcnt_q    <= wcnt_q + LEN_ONE;
      end
    end
  end

  // Run path: core reset, status flags and cycle counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      core_rst_n  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      core_rst_n <= (state_nxt == RUN);
      busy       <= (state_nxt == LOAD) || (state_nxt == RUN);
      done       <= (state_nxt == DONE);
      if (state_nxt != DONE) begin
        timeout <= 1'b0;
      end else if (state == RUN) begin
        timeout <= !halt;
      end
      if (run_entry) begin
        cycle_count <= '0;
      end else if (run_stay && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
// Bench for prog_load_run_ctrl: random programs and core fetch
// streams checked against a halt/budget reference model.
module tb_prog_load_run_ctrl;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int MAXC = 1000;
  localparam int SLEN = 1100;
  localparam logic [DW-1:0] HALT = 32'h0000006F;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [AW:0] prog_len = '0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_instr = '0;
  logic [DW-1:0] cur_instr = '0;

  logic in_ready;
  logic mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic core_rst_n;
  logic busy;
  logic done;
  logic timeout;
  logic [CW-1:0] cycle_count;

  prog_load_run_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW),
    .MAX_CYCLES(MAXC),
    .HALT_INSTR(HALT)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .start(start),
    .abort(abort),
    .prog_len(prog_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .mem_we(mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n),
    .cur_instr(cur_instr),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] sched [SLEN];
  logic [DW-1:0] prog [$];
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  int run_idx = 0;

  // Core model: the n-th fetch after release presents sched[n].
  always @(negedge clk) begin
    if (core_rst_n) begin
      cur_instr = (run_idx < SLEN) ? sched[run_idx] : HALT;
      run_idx++;
    end else begin
      cur_instr = '0;
      run_idx = 0;
    end
  end

  // Write monitor: every imem write ever issued.
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_waddr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = $urandom;
    if (w == HALT) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic fill_sched(input int halt_at);
    for (int k = 0; k < SLEN; k++) sched[k] = rand_word();
    if (halt_at >= 0 && halt_at < SLEN) sched[halt_at] = HALT;
  endtask

  task automatic rand_prog(input int len);
    prog.delete();
    for (int k = 0; k < len; k++) prog.push_back(rand_word());
  endtask

  // Reference: halted at first HALT fetch if within budget,
  // otherwise budget expiry at the last permitted cycle.
  function automatic void expect_run(output int cnt, output bit to);
    cnt = MAXC - 1;
    to = 1'b1;
    for (int k = 0; k < MAXC; k++) begin
      if (sched[k] == HALT) begin
        cnt = k;
        to = 1'b0;
        break;
      end
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_waddr"}, mem_waddr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_core_rst_n"}, core_rst_n, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // mode 0: back-to-back, 1: alternating valid, 2: random gaps.
  task automatic do_load(input int len, input int mode,
                         input bit extra);
    int i;
    int guard;
    bit acc;
    wa_q.delete();
    wd_q.delete();
    prog_len = (AW + 1)'(len);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_done_clr", done, 0);
    check("load_in_ready", in_ready, 1);
    i = 0;
    guard = 0;
    while (i < len && guard < 2000) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (guard % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_instr = prog[i];
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      check("load_mem_we", mem_we, acc);
      if (acc) begin
        check("load_waddr", mem_waddr, i);
        check("load_wdata", mem_wdata, prog[i]);
        i++;
      end
      guard++;
    end
    in_valid = 1'b0;
    check("load_complete", i, len);
    check("run_in_ready", in_ready, 0);
    check("run_core_rst_n", core_rst_n, 1);
    if (extra) begin
      in_valid = 1'b1;
      in_instr = rand_word();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("extra_mem_we", mem_we, 0);
    end
  endtask

  task automatic check_writes(input int len);
    check("write_count", wa_q.size(), len);
    for (int k = 0; k < len && k < wa_q.size(); k++) begin
      check("write_addr", wa_q[k], k);
      check("write_data", wd_q[k], prog[k]);
    end
  endtask

  task automatic run_wait(input string tag);
    int cnt;
    bit to;
    int c;
    expect_run(cnt, to);
    c = 0;
    while (!done && c < 1200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_timeout"}, timeout, to);
    check({tag, "_cycle_count"}, cycle_count, cnt);
    check({tag, "_core_rst_n"}, core_rst_n, 0);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_hold"}, done, 1);
    check({tag, "_count_hold"}, cycle_count, cnt);
  endtask

  initial begin
    int len;
    int h;

    // Reset
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: four-word program ending in halt
    prog.delete();
    prog.push_back(32'h00100093);
    prog.push_back(32'h00100113);
    prog.push_back(32'h002081B3);
    prog.push_back(HALT);
    fill_sched(-1);
    for (int k = 0; k < 4; k++) sched[k] = prog[k];
    do_load(4, 0, 1'b0);
    run_wait("t1");
    check_writes(4);

    // 2: gappy valid, extra word refused
    rand_prog(3);
    fill_sched($urandom_range(0, 40));
    do_load(3, 1, 1'b1);
    run_wait("t2");
    check_writes(3);

    // 3: endless loop hits budget
    prog.delete();
    prog.push_back(32'h00000063);
    fill_sched(-1);
    do_load(1, 0, 1'b0);
    run_wait("t3");

    // 4: halt on the last budget cycle
    fill_sched(MAXC - 1);
    do_load(1, 0, 1'b0);
    run_wait("t4");

    // 5a: abort during LOAD after two words
    @(posedge clk);
    #1;
    prog_len = 5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      in_instr = rand_word();
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    in_valid = 1'b0;
    check("abl_in_ready", in_ready, 0);
    check("abl_busy", busy, 0);
    check("abl_core_rst_n", core_rst_n, 0);
    check("abl_done", done, 0);
    check("abl_mem_we", mem_we, 0);
    prog_len = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("len0_busy", busy, 0);
    check("len0_in_ready", in_ready, 0);
    prog_len = 65;
    @(posedge clk);
    #1;
    check("len65_busy", busy, 0);
    prog_len = 3;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abst_busy", busy, 0);
    check("abst_in_ready", in_ready, 0);

    // 5b: abort during RUN, count holds
    rand_prog(2);
    fill_sched(-1);
    do_load(2, 0, 1'b0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abr_count", cycle_count, 7);
    check("abr_done", done, 0);
    check("abr_timeout", timeout, 0);
    check("abr_core_rst_n", core_rst_n, 0);
    check("abr_busy", busy, 0);
    check("abr_in_ready", in_ready, 0);
    check_writes(2);
    prog_len = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abr_len0_busy", busy, 0);

    // 6: async reset mid-run, then one-word halt program
    rand_prog(1);
    fill_sched(-1);
    do_load(1, 0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    prog.delete();
    prog.push_back(HALT);
    fill_sched(0);
    do_load(1, 0, 1'b0);
    run_wait("t6");
    check_writes(1);

    // Random programs and halt positions
    for (int t = 0; t < 5; t++) begin
      len = $urandom_range(1, 64);
      h = (t == 4) ? -1 : $urandom_range(0, 1050);
      rand_prog(len);
      fill_sched(h);
      do_load(len, 2, 1'b0);
      run_wait("rnd");
      check_writes(len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
